func3_sweep_ctrl: RTL and testbench

Sequencer that exhaustively drives the 4-input combinational block func3 (inputs a,b,c,d; outputs y,z) through all 16 input vectors.
- Holds each vector for a programmable dwell time, then samples y and z.
- Builds 16-bit truth-table maps of y and z and checks them on the fly against expected maps.
- Sits beside a func3 instance as its on-chip self-test and characterisation controller, under start/busy/done control.

---
 rtl/func3_sweep_ctrl.sv | 139 +++++++++++++
 tb/tb_func3_sweep_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/func3_sweep_ctrl.sv
// func3_sweep_ctrl: walks func3 through all 16 input vectors, captures y/z
// truth tables and compares them against expected maps while sweeping.
module func3_sweep_ctrl #(
   parameter int unsigned DWELL = 2,
   parameter int unsigned CNT_W = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] exp_y,
   input  logic [15:0] exp_z,
   input  logic        y,
   input  logic        z,
   output logic        a,
   output logic        b,
   output logic        c,
   output logic        d,
   output logic        busy,
   output logic        done,
   output logic        result_valid,
   output logic [15:0] y_map,
   output logic [15:0] z_map,
   output logic        mismatch,
   output logic [3:0]  first_fail
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

   state_t           state_q, state_d;
   logic [3:0]       vec_q, vec_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      ymap_q, ymap_d;
   logic [15:0]      zmap_q, zmap_d;
   logic             mm_q, mm_d;
   logic [3:0]       ff_q, ff_d;
   logic             rv_q, rv_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         ymap_q  <= '0;
         zmap_q  <= '0;
         mm_q    <= 1'b0;
         ff_q    <= '0;
         rv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         ymap_q  <= ymap_d;
         zmap_q  <= zmap_d;
         mm_q    <= mm_d;
         ff_q    <= ff_d;
         rv_q    <= rv_d;
      end
   end

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      ymap_d  = ymap_q;
      zmap_d  = zmap_q;
      mm_d    = mm_q;
      ff_d    = ff_q;
      rv_d    = rv_q;
      unique case (state_q)
         IDLE: begin
            vec_d = '0;
            cnt_d = '0;
            if (start && !abort) begin
               ymap_d  = '0;
               zmap_d  = '0;
               mm_d    = 1'b0;
               ff_d    = '0;
               rv_d    = 1'b0;
               state_d = DRIVE;
            end
         end
         DRIVE: begin
            // abort outranks a coincident sample edge: nothing is captured
            if (abort) begin
               vec_d   = '0;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  cnt_d = '0;
                  ymap_d[vec_q] = y;
                  zmap_d[vec_q] = z;
                  if ((y != exp_y[vec_q]) || (z != exp_z[vec_q])) begin
                     mm_d = 1'b1;
                     if (!mm_q) ff_d = vec_q;
                  end
                  if (vec_q == 4'hF) begin
                     vec_d   = '0;
                     state_d = DONE;
                  end else begin
                     vec_d = vec_q + 4'd1;
                  end
               end
            end
         end
         DONE: begin
            rv_d    = 1'b1;
            vec_d   = '0;
            state_d = IDLE;
         end
         default: begin
            vec_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   assign a            = vec_q[3];
   assign b            = vec_q[2];
   assign c            = vec_q[1];
   assign d            = vec_q[0];
   assign busy         = (state_q == DRIVE);
   assign done         = (state_q == DONE);
   assign result_valid = rv_q;
   assign y_map        = ymap_q;
   assign z_map        = zmap_q;
   assign mismatch     = mm_q;
   assign first_fail   = ff_q;

endmodule

// File: tb/tb_func3_sweep_ctrl.sv
// tb_func3_sweep_ctrl: three controllers (DWELL 1/2/5) share stimulus and
// each drives its own func3 stand-in built from the truth tables fy/fz.
module tb_func3_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, start, abort;
   logic [15:0] exp_y, exp_z, fy, fz;

   logic [2:0]  a_w, b_w, c_w, d_w, y_w, z_w;
   logic [2:0]  busy_w, done_w, rv_w, mm_w;
   logic [15:0] ymap_w [3];
   logic [15:0] zmap_w [3];
   logic [3:0]  ff_w [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic int dw(input int g);
      return (g == 0) ? 1 : (g == 1) ? 2 : 5;
   endfunction

   function automatic int lowest(input logic [15:0] v);
      for (int i = 0; i < 16; i++) if (v[i]) return i;
      return 0;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned D = dw(g);
      assign y_w[g] = fy[{a_w[g], b_w[g], c_w[g], d_w[g]}];
      assign z_w[g] = fz[{a_w[g], b_w[g], c_w[g], d_w[g]}];
      func3_sweep_ctrl #(.DWELL(D), .CNT_W(8)) u_dut (
         .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
         .exp_y(exp_y), .exp_z(exp_z), .y(y_w[g]), .z(z_w[g]),
         .a(a_w[g]), .b(b_w[g]), .c(c_w[g]), .d(d_w[g]),
         .busy(busy_w[g]), .done(done_w[g]), .result_valid(rv_w[g]),
         .y_map(ymap_w[g]), .z_map(zmap_w[g]),
         .mismatch(mm_w[g]), .first_fail(ff_w[g])
      );
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      exp_y = '0; exp_z = '0; fy = '0; fz = '0;
      tick; tick;
      for (int g = 0; g < 3; g++) begin
         checks++;
         if ({busy_w[g], done_w[g], rv_w[g], mm_w[g], ff_w[g],
              a_w[g], b_w[g], c_w[g], d_w[g]} !== 12'h0 ||
             ymap_w[g] !== 16'h0 || zmap_w[g] !== 16'h0) begin
            errors++;
            $display("FAIL reset g%0d busy=%b done=%b rv=%b mm=%b ff=%0d ym=%h zm=%h want all 0",
                     g, busy_w[g], done_w[g], rv_w[g], mm_w[g], ff_w[g],
                     ymap_w[g], zmap_w[g]);
         end
      end
      rst_n = 1'b1;
      tick;
   endtask

   task automatic run_sweep(input string tag);
      logic [15:0] diff;
      int D;
      bit eb, ed, erv;
      int ev;
      diff = (fy ^ exp_y) | (fz ^ exp_z);
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int t = 1; t <= 82; t++) begin
         for (int g = 0; g < 3; g++) begin
            D   = dw(g);
            eb  = (t <= 16 * D);
            ed  = (t == 16 * D + 1);
            erv = (t > 16 * D + 1);
            ev  = eb ? (t - 1) / D : 0;
            checks++;
            if (busy_w[g] !== eb || done_w[g] !== ed || rv_w[g] !== erv) begin
               errors++;
               $display("FAIL %s ctl g%0d t=%0d busy/done/rv=%b%b%b want %b%b%b",
                        tag, g, t, busy_w[g], done_w[g], rv_w[g], eb, ed, erv);
            end
            checks++;
            if ({a_w[g], b_w[g], c_w[g], d_w[g]} !== 4'(ev)) begin
               errors++;
               $display("FAIL %s vec g%0d t=%0d abcd=%b want %b", tag, g, t,
                        {a_w[g], b_w[g], c_w[g], d_w[g]}, 4'(ev));
            end
            if (t == 82) begin
               checks++;
               if (ymap_w[g] !== fy || zmap_w[g] !== fz) begin
                  errors++;
                  $display("FAIL %s maps g%0d y=%h z=%h want %h %h", tag, g,
                           ymap_w[g], zmap_w[g], fy, fz);
               end
               checks++;
               if (mm_w[g] !== (diff != 0) || ff_w[g] !== 4'(lowest(diff))) begin
                  errors++;
                  $display("FAIL %s flags g%0d mm=%b ff=%0d want %b %0d", tag, g,
                           mm_w[g], ff_w[g], diff != 0, lowest(diff));
               end
            end
         end
         tick;
      end
   endtask

   task automatic test_basic;
      for (int i = 0; i < 16; i++) begin
         fy[i] = i[3] & i[2];
         fz[i] = i[1] | i[0];
      end
      exp_y = 16'hF000; exp_z = 16'hEEEE;
      run_sweep("basic");
   endtask

   task automatic test_mismatch;
      exp_y = 16'hF020; exp_z = 16'hEEEA;
      run_sweep("mismatch");
   endtask

   task automatic test_random;
      logic [15:0] my, mz;
      for (int k = 0; k < 4; k++) begin
         fy = 16'($urandom); fz = 16'($urandom);
         my = 16'($urandom & $urandom & $urandom);
         mz = 16'($urandom & $urandom & $urandom);
         if (k == 0) begin my = '0; mz = '0; end
         exp_y = fy ^ my; exp_z = fz ^ mz;
         run_sweep("random");
      end
   endtask

   task automatic test_reset_mid;
      fy = 16'hFFFF; fz = 16'($urandom);
      exp_y = 16'h0001; exp_z = fz;
      start = 1'b1;
      tick;
      start = 1'b0;
      repeat (9) tick;
      rst_n = 1'b0;
      tick;
      for (int g = 0; g < 3; g++) begin
         checks++;
         if ({busy_w[g], done_w[g], rv_w[g], mm_w[g], ff_w[g],
              a_w[g], b_w[g], c_w[g], d_w[g]} !== 12'h0 ||
             ymap_w[g] !== 16'h0 || zmap_w[g] !== 16'h0) begin
            errors++;
            $display("FAIL rst_mid g%0d busy=%b done=%b rv=%b mm=%b ff=%0d ym=%h zm=%h want all 0",
                     g, busy_w[g], done_w[g], rv_w[g], mm_w[g], ff_w[g],
                     ymap_w[g], zmap_w[g]);
         end
      end
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_abort;
      logic [15:0] mask, diff;
      int n;
      fy = 16'($urandom); fz = 16'($urandom);
      exp_y = fy; exp_z = fz ^ 16'h0004;
      start = 1'b1;
      tick;
      start = 1'b0;
      repeat (8) tick;
      abort = 1'b1;
      tick;
      abort = 1'b0;
      for (int g = 0; g < 3; g++) begin
         n    = 8 / dw(g);
         mask = 16'((32'd1 << n) - 1);
         diff = ((fy ^ exp_y) | (fz ^ exp_z)) & mask;
         checks++;
         if ({busy_w[g], done_w[g], rv_w[g], a_w[g], b_w[g], c_w[g], d_w[g]} !== 7'h0) begin
            errors++;
            $display("FAIL abort g%0d busy=%b done=%b rv=%b abcd=%b want 0", g,
                     busy_w[g], done_w[g], rv_w[g],
                     {a_w[g], b_w[g], c_w[g], d_w[g]});
         end
         checks++;
         if (ymap_w[g] !== (fy & mask) || zmap_w[g] !== (fz & mask)) begin
            errors++;
            $display("FAIL abort_map g%0d y=%h z=%h want %h %h", g,
                     ymap_w[g], zmap_w[g], fy & mask, fz & mask);
         end
         checks++;
         if (mm_w[g] !== (diff != 0) || ff_w[g] !== 4'(lowest(diff))) begin
            errors++;
            $display("FAIL abort_flags g%0d mm=%b ff=%0d want %b %0d", g,
                     mm_w[g], ff_w[g], diff != 0, lowest(diff));
         end
      end
      for (int t = 0; t < 20; t++) begin
         checks++;
         if (busy_w !== 3'b0 || done_w !== 3'b0 || rv_w !== 3'b0) begin
            errors++;
            $display("FAIL abort_idle t=%0d busy=%b done=%b rv=%b want 0", t,
                     busy_w, done_w, rv_w);
         end
         tick;
      end
   endtask

   task automatic test_priority;
      int D, p;
      bit eb, ed;
      start = 1'b1; abort = 1'b1;
      tick;
      start = 1'b0; abort = 1'b0;
      for (int t = 0; t < 3; t++) begin
         checks++;
         if (busy_w !== 3'b0 || done_w !== 3'b0) begin
            errors++;
            $display("FAIL prio t=%0d busy=%b done=%b want 0", t, busy_w, done_w);
         end
         tick;
      end
      start = 1'b1;
      tick;
      for (int t = 1; t <= 40; t++) begin
         for (int g = 0; g < 3; g++) begin
            D  = dw(g);
            p  = t % (16 * D + 2);
            eb = (p >= 1) && (p <= 16 * D);
            ed = (p == 16 * D + 1);
            checks++;
            if (busy_w[g] !== eb || done_w[g] !== ed) begin
               errors++;
               $display("FAIL held g%0d t=%0d busy/done=%b%b want %b%b", g, t,
                        busy_w[g], done_w[g], eb, ed);
            end
         end
         tick;
      end
      start = 1'b0;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      tick;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset;
      test_basic;
      test_mismatch;
      test_random;
      test_reset_mid;
      test_abort;
      test_priority;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
